fb_scanout_reader: RTL
======================

// Module: fb_scanout_reader
// PURPOSE
//  Read side of the GPU/SRAM framebuffer. The GPU fills the 640x400 framebuffer
//    (addr = row*640 + col, 16-bit word = {X,R,G,B} nibbles).
//  This block fetches those words sequentially, buffers them in a prefetch FIFO
//    and delivers one RGB pixel per display pixel strobe.
//  It sits between the SRAM arbiter (read port) and the VGA timing/DAC path.
// PARAMETERS
//  H_RES      640     pixels per line
//  V_RES      400     lines per frame; frame size = H_RES*V_RES words
//  FIFO_DEPTH 16      prefetch FIFO entries (power of 2)
//  RD_LAT     2       cycles from accepted read (O_SRAM_READ & I_SRAM_GNT) to I_SRAM_DATA valid
// PORTS
//  I_CLK          in   1   system clock
//  I_RST          in   1   synchronous reset, active-high
//  I_FRAME_START  in   1   1-cycle pulse before first pixel of a frame
//  I_VIDEO_ON     in   1   display active region
//  I_PIX_REQ      in   1   pixel strobe; only honoured while I_VIDEO_ON=1
//  O_SRAM_ADDR    out  18  read word address
//  O_SRAM_READ    out  1   read request, held until granted
//  I_SRAM_GNT     in   1   arbiter accepts the read this cycle
//  I_SRAM_DATA    in   16  read data, valid RD_LAT cycles after acceptance
//  O_PIX_R/G/B    out  4   pixel colour (each 4 bits)
//  O_PIX_VALID    out  1   1-cycle pulse per honoured I_PIX_REQ
//  O_UNDERFLOW    out  1   sticky: a pixel request found the FIFO empty
// BEHAVIOUR
//  Reset (I_RST=1 at edge):
//    outputs 0: O_SRAM_ADDR, O_SRAM_READ, O_PIX_R/G/B, O_PIX_VALID, O_UNDERFLOW
//    FIFO emptied; in-flight count=0; FSM->IDLE; returns beyond reset are discarded
//  FSM:
//    IDLE  -> FILL on I_FRAME_START
//    FILL  : issues reads; -> RUN when FIFO full (count+inflight == FIFO_DEPTH)
//    RUN   : keeps issuing reads while count+inflight < FIFO_DEPTH;
//            -> DONE after the last word (addr H_RES*V_RES-1) is accepted
//    DONE  : no reads; drains FIFO; -> IDLE when FIFO empty
//  I_FRAME_START in any state:
//    flush FIFO; O_SRAM_ADDR=0; O_UNDERFLOW cleared; -> FILL
//    an in-flight read is dropped (counted down, data not written)
//  Read handshake:
//    O_SRAM_READ/O_SRAM_ADDR are stable until the cycle I_SRAM_GNT=1
//    O_SRAM_ADDR increments on acceptance; inflight+1
//    the return is written to the FIFO RD_LAT cycles later; inflight-1
//    never more than FIFO_DEPTH words reserved (FIFO + inflight): no overflow possible
//  Pixel path:
//    I_PIX_REQ & I_VIDEO_ON & FIFO not empty:
//      next cycle O_PIX_VALID=1, R/G/B = word[11:8]/[7:4]/[3:0], FIFO pops; word[15:12] ignored
//    I_PIX_REQ & I_VIDEO_ON & FIFO empty:
//      next cycle O_PIX_VALID=1, RGB=0 (black), O_UNDERFLOW=1 (sticky), no pop
//    I_PIX_REQ with I_VIDEO_ON=0: ignored
//    R/G/B hold their last value between strobes
//  Simultaneous FIFO push (return) and pop in one cycle: both occur, count unchanged
//  Address arithmetic: 18-bit counter, 0..H_RES*V_RES-1; no wrap past the frame end
//    (DONE stops reads); the new frame restarts at 0
// TESTING
//  T1 reset mid-FILL (I_RST high 1 cycle): all outputs 0 next cycle;
//     a pending return 2 cycles later is not pushed into the FIFO
//  T2 I_FRAME_START, I_SRAM_GNT=1 always: addresses 0..15 on consecutive cycles,
//     then O_SRAM_READ=0; FIFO count=16 at cycle 18
//  T3 SRAM preloaded word[n]=n: 20 pixel strobes
//     -> RGB sequence {0,0,0},{0,0,1}..{0,1,3}; O_UNDERFLOW=0
//  T4 GNT held low 10 cycles: O_SRAM_ADDR/O_SRAM_READ unchanged; strobes drain the FIFO;
//     then the 17th strobe gives RGB=0, O_UNDERFLOW=1, sticky until next I_FRAME_START
//  T5 full frame, 1 strobe per 2 clocks, GNT=1:
//     256000 O_PIX_VALID pulses; last read addr 255999; FSM reaches IDLE
//  T6 I_FRAME_START at pixel 1000 with 1 read in flight:
//     next read addr 0; first pixel out = word[0]; the dropped word is never output

Source files
------------

// File: rtl/fb_scanout_reader_if.sv
// Bus bundle for fb_scanout_reader: display-side pixel handshake plus the
// SRAM arbiter read port.
//   master : the scanout reader (drives SRAM read request and pixel outputs)
//   slave  : the environment (video timing, SRAM arbiter / memory)
// Signals:
//   frame_start  1-cycle pulse before the first pixel of a frame
//   video_on     display active region
//   pix_req      pixel strobe, honoured only while video_on=1
//   sram_addr    18-bit read word address
//   sram_read    read request, held until granted
//   sram_gnt     arbiter accepts the read this cycle
//   sram_data    16-bit read data {X,R,G,B}, valid RD_LAT cycles after acceptance
//   pix_r/g/b    4-bit pixel colour
//   pix_valid    1-cycle pulse per honoured pixel strobe
//   underflow    sticky: a pixel strobe found the FIFO empty
interface fb_scanout_reader_if;
  logic        frame_start;
  logic        video_on;
  logic        pix_req;
  logic [17:0] sram_addr;
  logic        sram_read;
  logic        sram_gnt;
  logic [15:0] sram_data;
  logic [3:0]  pix_r;
  logic [3:0]  pix_g;
  logic [3:0]  pix_b;
  logic        pix_valid;
  logic        underflow;

  modport master (
    input  frame_start, video_on, pix_req, sram_gnt, sram_data,
    output sram_addr, sram_read, pix_r, pix_g, pix_b, pix_valid, underflow
  );

  modport slave (
    output frame_start, video_on, pix_req, sram_gnt, sram_data,
    input  sram_addr, sram_read, pix_r, pix_g, pix_b, pix_valid, underflow
  );
endinterface

// File: rtl/fb_scanout_reader.sv
// Framebuffer scanout reader. Fetches framebuffer words sequentially from the
// SRAM arbiter read port, buffers them in a prefetch FIFO and delivers one RGB
// pixel per honoured display pixel strobe.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous reset, active-high
//   bus    fb_scanout_reader_if.master (SRAM read port + pixel outputs)
// Parameters:
//   H_RES, V_RES  frame geometry; frame = H_RES*V_RES words starting at address 0
//   FIFO_DEPTH    prefetch FIFO entries (power of 2)
//   RD_LAT        cycles from accepted read to valid read data
module fb_scanout_reader #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 400,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fb_scanout_reader_if.master  bus
);

  localparam int unsigned LAST_ADDR = H_RES * V_RES - 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned RES_W     = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [17:0]       addr_q, addr_d;
  // Only the R/G/B nibbles are stored; the X nibble is never displayed.
  logic [11:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  // One bit per outstanding read; the top bit marks the return arriving now.
  logic [RD_LAT-1:0] ret_pipe_q;
  logic [11:0]       pix_rgb_q;
  logic              pix_valid_q;
  logic              underflow_q;

  logic [CNT_W-1:0]  inflight;
  logic [RES_W-1:0]  reserved;
  logic              issue;
  logic              accept;
  logic              last_accept;
  logic              push;
  logic              pop_req;
  logic              fifo_empty;
  logic              pop;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(ret_pipe_q[i]);
    end
  end

  // Reserving FIFO slots for in-flight reads makes overflow impossible.
  // The request can only drop through acceptance: pushes move a slot from
  // inflight to count, and pops only free slots.
  assign reserved    = RES_W'(count_q) + RES_W'(inflight);
  assign issue       = ((state_q == S_FILL) || (state_q == S_RUN)) &&
                       (reserved < RES_W'(FIFO_DEPTH));
  assign accept      = issue && bus.sram_gnt;
  assign last_accept = accept && (addr_q == 18'(LAST_ADDR));
  assign push        = ret_pipe_q[RD_LAT-1];
  assign pop_req     = bus.pix_req && bus.video_on;
  assign fifo_empty  = (count_q == '0);
  assign pop         = pop_req && !fifo_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_FILL: begin
        if (last_accept) begin
          state_d = S_DONE;
        end else if (reserved == RES_W'(FIFO_DEPTH)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last_accept) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Wait for outstanding returns as well, so none lands after IDLE.
        if (fifo_empty && (inflight == '0)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.frame_start) begin
      state_d = S_FILL;
    end
  end

  // Address holds at the last frame word; the next frame restarts at 0.
  always_comb begin
    addr_d = addr_q;
    if (accept && !last_accept) begin
      addr_d = addr_q + 18'd1;
    end
    if (bus.frame_start) begin
      addr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ret_pipe_q  <= '0;
      pix_rgb_q   <= '0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;

      if (bus.frame_start) begin
        // Clearing the return pipe drops in-flight data without writing it.
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        ret_pipe_q <= '0;
      end else begin
        ret_pipe_q <= (ret_pipe_q << 1) | RD_LAT'(accept);
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end

      pix_valid_q <= pop_req;
      if (pop_req) begin
        if (fifo_empty) begin
          pix_rgb_q   <= '0;
          underflow_q <= 1'b1;
        end else begin
          pix_rgb_q <= fifo_mem_q[rd_ptr_q];
        end
      end
      if (bus.frame_start) begin
        underflow_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset; a write without a pointer advance is harmless.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= bus.sram_data[11:0];
    end
  end

  assign bus.sram_addr = addr_q;
  assign bus.sram_read = issue;
  assign bus.pix_r     = pix_rgb_q[11:8];
  assign bus.pix_g     = pix_rgb_q[7:4];
  assign bus.pix_b     = pix_rgb_q[3:0];
  assign bus.pix_valid = pix_valid_q;
  assign bus.underflow = underflow_q;

endmodule
